// File: rtl/gru_h_update.sv
// gru_h_update -- GRU forward-pass hidden-state update.
//
// Computes h_t = h_prev + z*(h_cand - h_prev) per lane. All values are signed
// Q2.14 (1.0 = 0x4000). Lanes go one per cycle through a shared two-stage
// multiply/add pipeline. Results collect in a staging register and appear on
// `out` all together.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   en           start request, sampled only while busy=0
//   z            update gate; lane i is at [DATABIT*i +: DATABIT]
//   h_prev       previous hidden state, same packing
//   h_cand       candidate hidden state, same packing
//   busy         high while a vector is in flight
//   result_valid one-cycle pulse when out carries a new result
//   out          new hidden state, held between results
//
// Build option:
//   GRU_HUPD_SAT_EN  defined: clamp each lane to the DATABIT signed range.
//                    undefined: keep the low DATABIT bits (two's-complement wrap).
module gru_h_update #(
  parameter int DATABIT = 16,
  parameter int FRAC    = 14,
  parameter int LANES   = 4,
  localparam int HTNUM  = DATABIT * LANES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [HTNUM-1:0] z,
  input  logic [HTNUM-1:0] h_prev,
  input  logic [HTNUM-1:0] h_cand,
  output logic             busy,
  output logic             result_valid,
  output logic [HTNUM-1:0] out
);

  localparam int CNT_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PROD_W = 2 * DATABIT + 1;
  localparam int SUM_W  = 2 * DATABIT + 2;
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

`ifdef GRU_HUPD_SAT_EN
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((64'sd1 <<< (DATABIT - 1)) - 64'sd1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(64'sd1 <<< (DATABIT - 1)));
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                    state;
  logic [CNT_W-1:0]          lane_cnt;
  logic [HTNUM-1:0]          z_q, hp_q, hc_q, stage_q;

  logic signed [DATABIT-1:0] z_p0, hp_p0, hc_p0;
  logic signed [DATABIT:0]   diff_p0;
  logic signed [PROD_W-1:0]  prod_p0;

  logic                      vld_p1;
  logic [CNT_W-1:0]          lane_p1;
  logic signed [PROD_W-1:0]  prod_p1;
  logic signed [DATABIT-1:0] hp_p1;
  logic signed [PROD_W-1:0]  scaled_p1;
  logic signed [SUM_W-1:0]   sum_p1;

  // Reduce a full-width sum to one output lane.
  function automatic logic [DATABIT-1:0] fit_lane(input logic signed [SUM_W-1:0] s);
`ifdef GRU_HUPD_SAT_EN
    if (s > SAT_MAX)
      fit_lane = SAT_MAX[DATABIT-1:0];
    else if (s < SAT_MIN)
      fit_lane = SAT_MIN[DATABIT-1:0];
    else
      fit_lane = s[DATABIT-1:0];
`else
    fit_lane = s[DATABIT-1:0];
`endif
  endfunction

  // Stage 0: select the issued lane, widen the difference, multiply by z.
  assign z_p0    = z_q[lane_cnt*DATABIT +: DATABIT];
  assign hp_p0   = hp_q[lane_cnt*DATABIT +: DATABIT];
  assign hc_p0   = hc_q[lane_cnt*DATABIT +: DATABIT];
  assign diff_p0 = {hc_p0[DATABIT-1], hc_p0} - {hp_p0[DATABIT-1], hp_p0};
  assign prod_p0 = z_p0 * diff_p0;

  // Stage 1: rescale the product (floor) and add back h_prev at full width.
  assign scaled_p1 = prod_p1 >>> FRAC;
  assign sum_p1    = scaled_p1 + hp_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lane_cnt     <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      out          <= '0;
      z_q          <= '0;
      hp_q         <= '0;
      hc_q         <= '0;
      stage_q      <= '0;
      vld_p1       <= 1'b0;
      lane_p1      <= '0;
      prod_p1      <= '0;
      hp_p1        <= '0;
    end else begin
      result_valid <= 1'b0;

      vld_p1  <= (state == RUN);
      lane_p1 <= lane_cnt;
      prod_p1 <= prod_p0;
      hp_p1   <= hp_p0;

      // Stage 2: write the finished lane into the staging register.
      if (vld_p1)
        stage_q[lane_p1*DATABIT +: DATABIT] <= fit_lane(sum_p1);

      case (state)
        IDLE: begin
          if (en) begin
            z_q      <= z;
            hp_q     <= h_prev;
            hc_q     <= h_cand;
            lane_cnt <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          lane_cnt <= lane_cnt + 1'b1;
          if (lane_cnt == LAST_LANE)
            state <= DRAIN;
        end
        DRAIN: begin
          busy  <= 1'b0;
          state <= DONE;
        end
        DONE: begin
          out          <= stage_q;
          result_valid <= 1'b1;
          // busy is already low here, so a new vector can start immediately.
          if (en) begin
            z_q      <= z;
            hp_q     <= h_prev;
            hc_q     <= h_cand;
            lane_cnt <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gru_h_update.sv
// tb_gru_h_update -- randomized and directed bench for gru_h_update.
// Expected hidden states come from a per-lane integer model of
// h + floor(z*(c-h)/2^14), clamped or wrapped to 16 bits.
module tb_gru_h_update;

  localparam int DATABIT = 16;
  localparam int FRAC    = 14;
  localparam int LANES   = 4;
  localparam int HTNUM   = DATABIT * LANES;
  localparam int LAT     = LANES + 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [HTNUM-1:0] z, h_prev, h_cand;
  logic             busy;
  logic             result_valid;
  logic [HTNUM-1:0] out;

  int n_cmp = 0;
  int n_err = 0;

  gru_h_update #(.DATABIT(DATABIT), .FRAC(FRAC), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .en(en), .z(z), .h_prev(h_prev), .h_cand(h_cand),
    .busy(busy), .result_valid(result_valid), .out(out)
  );

  always #5 clk = ~clk;

  function automatic logic [HTNUM-1:0] model(input logic [HTNUM-1:0] zv,
                                             input logic [HTNUM-1:0] hv,
                                             input logic [HTNUM-1:0] cv);
    logic [HTNUM-1:0] r;
    logic signed [15:0] a, b, c;
    longint zi, hi, ci, s;
    r = '0;
    for (int i = 0; i < LANES; i++) begin
      a = zv[i*DATABIT +: DATABIT];
      b = hv[i*DATABIT +: DATABIT];
      c = cv[i*DATABIT +: DATABIT];
      zi = a; hi = b; ci = c;
      s = ((zi * (ci - hi)) >>> FRAC) + hi;
`ifdef GRU_HUPD_SAT_EN
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
`endif
      r[i*DATABIT +: DATABIT] = s[15:0];
    end
    return r;
  endfunction

  function automatic logic [HTNUM-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic start(input logic [HTNUM-1:0] zv, input logic [HTNUM-1:0] hv,
                       input logic [HTNUM-1:0] cv);
    z = zv; h_prev = hv; h_cand = cv; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    z = rnd64(); h_prev = rnd64(); h_cand = rnd64();
  endtask

  // Counts edges until result_valid is seen, bounded at 20.
  task automatic wait_rv(output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!result_valid && edges < 20);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; z = '0; h_prev = '0; h_cand = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL reset_rv got=%b want=0", result_valid); end
    n_cmp++; if (out !== '0) begin n_err++; $display("FAIL reset_out got=%h want=0", out); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [HTNUM-1:0] tz[5], th[5], tc[5], te[5];
    int e;
    tz[0] = '0;
    th[0] = {16'h7FFF, 16'h0001, 16'hF000, 16'h1234};
    tc[0] = rnd64();
    te[0] = th[0];
    tz[1] = {4{16'h4000}};
    th[1] = '0;
    tc[1] = {16'hFFFF, 16'h2000, 16'hC000, 16'h0ABC};
    te[1] = tc[1];
    tz[2] = {4{16'h2000}}; th[2] = {4{16'h4000}}; tc[2] = '0;          te[2] = {4{16'h2000}};
    tz[3] = {4{16'h1000}}; th[3] = '0;            tc[3] = {4{16'h4000}}; te[3] = {4{16'h1000}};
    tz[4] = {4{16'h7FFF}}; th[4] = {4{16'h8000}}; tc[4] = {4{16'h7FFF}};
`ifdef GRU_HUPD_SAT_EN
    te[4] = {4{16'h7FFF}};
`else
    te[4] = {4{16'h7FFA}};
`endif
    for (int k = 0; k < 5; k++) begin
      start(tz[k], th[k], tc[k]);
      wait_rv(e);
      n_cmp++; if (e !== LAT) begin n_err++; $display("FAIL dir%0d_latency got=%0d want=%0d", k, e, LAT); end
      n_cmp++; if (out !== te[k]) begin n_err++; $display("FAIL dir%0d_out got=%h want=%h", k, out, te[k]); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL dir%0d_busy got=%b want=0", k, busy); end
      @(posedge clk); #1;
      n_cmp++; if (result_valid !== 1'b0) begin n_err++; $display("FAIL dir%0d_pulse got=%b want=0", k, result_valid); end
    end
  endtask

  task automatic test_random();
    logic [HTNUM-1:0] zv, hv, cv, exp;
    int e;
    for (int k = 0; k < 10; k++) begin
      zv = rnd64(); hv = rnd64(); cv = rnd64();
      if (k % 2 == 0)
        for (int i = 0; i < LANES; i++)
          zv[i*DATABIT +: DATABIT] = 16'($urandom_range(0, 16384));
      exp = model(zv, hv, cv);
      start(zv, hv, cv);
      wait_rv(e);
      n_cmp++; if (e !== LAT) begin n_err++; $display("FAIL rnd%0d_latency got=%0d want=%0d", k, e, LAT); end
      n_cmp++; if (out !== exp) begin n_err++; $display("FAIL rnd%0d_out got=%h want=%h", k, out, exp); end
    end
  endtask

  task automatic test_ignore_en();
    logic [HTNUM-1:0] za, ha, ca, exp;
    int e, pulses;
    za = rnd64(); ha = rnd64(); ca = rnd64();
    exp = model(za, ha, ca);
    start(za, ha, ca);
    en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    wait_rv(e);
    n_cmp++; if (e !== LAT - 1) begin n_err++; $display("FAIL ign_latency got=%0d want=%0d", e + 1, LAT); end
    n_cmp++; if (out !== exp) begin n_err++; $display("FAIL ign_out got=%h want=%h", out, exp); end
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (result_valid) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL ign_extra_pulses got=%0d want=0", pulses); end
  endtask

  task automatic test_back_to_back();
    logic [HTNUM-1:0] za, ha, ca, zb, hb, cb;
    int e;
    za = rnd64(); ha = rnd64(); ca = rnd64();
    zb = rnd64(); hb = rnd64(); cb = rnd64();
    start(za, ha, ca);
    wait_rv(e);
    n_cmp++; if (out !== model(za, ha, ca)) begin n_err++; $display("FAIL b2b_first_out got=%h want=%h", out, model(za, ha, ca)); end
    start(zb, hb, cb);
    wait_rv(e);
    n_cmp++; if (e !== LAT) begin n_err++; $display("FAIL b2b_latency got=%0d want=%0d", e, LAT); end
    n_cmp++; if (out !== model(zb, hb, cb)) begin n_err++; $display("FAIL b2b_second_out got=%h want=%h", out, model(zb, hb, cb)); end
  endtask

  task automatic test_reset_mid();
    logic [HTNUM-1:0] zb, hb, cb;
    int e, pulses;
    start(rnd64(), rnd64(), rnd64());
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
    n_cmp++; if (out !== '0) begin n_err++; $display("FAIL mid_rst_out got=%h want=0", out); end
    pulses = 0;
    repeat (10) begin
      if (result_valid) pulses++;
      @(posedge clk); #1;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL mid_rst_rv got=%0d want=0", pulses); end
    zb = rnd64(); hb = rnd64(); cb = rnd64();
    start(zb, hb, cb);
    wait_rv(e);
    n_cmp++; if (e !== LAT) begin n_err++; $display("FAIL after_rst_latency got=%0d want=%0d", e, LAT); end
    n_cmp++; if (out !== model(zb, hb, cb)) begin n_err++; $display("FAIL after_rst_out got=%h want=%h", out, model(zb, hb, cb)); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_en();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gru_h_update.md
Name: gru_h_update

Overview:
- Forward-pass counterpart of the GRU hidden-layer derivative datapath.
- Computes the new hidden state per lane: h_t = h_prev + z*(h_cand - h_prev), i.e. (1-z)*h_prev + z*h_cand.
- Inputs are the update-gate vector z, the previous state h_prev and the candidate state h_cand, all signed fixed point with 1.0 = 0x4000.
- Lanes are serialised through one multiply/add pipeline. The block sits between the gate/candidate units and the hidden-state register file, using the same en / result_valid handshake as the other hidden-layer arithmetic blocks.

Parameters:
- DATABIT, 16, lane width in bits (signed two's complement)
- FRAC, 14, fractional bits (Q2.14, 1.0 = 0x4000)
- LANES, 4, number of lanes; packed vector width HTNUM = DATABIT*LANES

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  start request; sampled only while busy=0
- z  in  HTNUM  update gate, lane i at [DATABIT*i +: DATABIT]
- h_prev  in  HTNUM  previous hidden state, same packing
- h_cand  in  HTNUM  candidate hidden state, same packing
- busy  out  1  high while a vector is in flight
- result_valid  out  1  one-cycle pulse, out valid
- out  out  HTNUM  new hidden state, same packing; held between results

Behaviour:
- Reset (rst=1 at edge): busy=0, result_valid=0, out=0, FSM to IDLE, all pipeline and staging registers cleared. Reset mid-operation aborts the vector with no result_valid.
- FSM states:
  - IDLE: on en=1, latch z, h_prev, h_cand, clear lane counter, go to RUN, busy=1.
  - RUN: issue lane k each cycle, k = 0..LANES-1; after lane LANES-1 is issued, go to DRAIN.
  - DRAIN: one cycle for the last lane to leave stage 2, then go to DONE.
  - DONE: copy staging register to out, result_valid=1 for exactly one cycle, busy=0, go to IDLE.
- Handshake:
  - en while busy=1 is ignored; inputs may change freely after the accepting edge.
  - busy is low in the DONE cycle, so an en in that cycle is accepted (back-to-back throughput of one vector every LANES+2 cycles).
- Latency: result_valid is high in the cycle following the (LANES+2)-th rising edge after the edge that sampled en (6 edges for LANES=4).
- Stage 1 (lane k):
  - diff = h_cand[k] - h_prev[k], computed at DATABIT+1 bits, no overflow.
  - prod = z[k] * diff, signed, 2*DATABIT+1 bits, registered.
- Stage 2 (lane k):
  - scaled = prod >>> FRAC (arithmetic shift, truncation toward -inf).
  - sum = scaled + h_prev[k], computed at full width.
  - Result goes through the saturation/wrap rule (see Optional Feature) and is written to staging lane k.
- out changes only in the DONE cycle, updating all lanes atomically. Partial results are never visible on out.
- z is not range-checked. Values outside 0..0x4000 extrapolate and rely on the overflow rule.

Optional Feature:
- Macro: GRU_HUPD_SAT_EN.
- Defined: sum is clamped to [-2^(DATABIT-1), 2^(DATABIT-1)-1], i.e. 0x8000..0x7FFF for DATABIT=16.
- Undefined: sum is truncated to its low DATABIT bits (two's-complement wrap), with no clamp logic.

Test Plan:
- z=0x0000 all lanes, h_prev lanes {0x1234,0xF000,0x0001,0x7FFF}, h_cand arbitrary, en pulse -> exactly 6 edges later result_valid=1 for one cycle, out equals h_prev lane-for-lane, busy low that cycle.
- z=0x4000 all lanes, h_prev=0x0000, h_cand lanes {0x0ABC,0xC000,0x2000,0xFFFF} -> out equals h_cand.
- z=0x2000, h_prev=0x4000, h_cand=0x0000, all lanes -> out lanes 0x2000. Then z=0x1000, h_prev=0x0000, h_cand=0x4000 -> out lanes 0x1000.
- Overflow case: z=0x7FFF, h_prev=0x8000, h_cand=0x7FFF -> out lanes 0x7FFF with GRU_HUPD_SAT_EN, 0x7FFA without.
- Second en pulsed while busy=1 -> ignored, only one result_valid. A new en in the result_valid cycle -> accepted, next result_valid 6 edges later with out from the new operands.
- rst=1 for one cycle, 3 edges after en -> busy=0, out=0x0, no result_valid. The next en runs normally with correct out.
